// File: rtl/axi_lite_req_arbiter_if.sv
// rtl/axi_lite_req_arbiter_if.sv - AXI-Lite channel bundle with master/slave views
interface AXI_LITE #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // write address channel
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [2:0]            aw_prot;
    logic                  aw_valid;
    logic                  aw_ready;
    // write data channel
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_valid;
    logic                  w_ready;
    // write response channel
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  b_ready;
    // read address channel
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]            ar_prot;
    logic                  ar_valid;
    logic                  ar_ready;
    // read data channel
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_valid;
    logic                  r_ready;

    modport Master (
        output aw_addr, aw_prot, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_valid,
        input  w_ready,
        input  b_resp, b_valid,
        output b_ready,
        output ar_addr, ar_prot, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_addr, aw_prot, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_valid,
        output w_ready,
        output b_resp, b_valid,
        input  b_ready,
        input  ar_addr, ar_prot, ar_valid,
        output ar_ready,
        output r_data, r_resp, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_lite_req_arbiter.sv
// rtl/axi_lite_req_arbiter.sv - round-robin arbiter sharing one AXI-Lite master port
module axi_lite_req_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    AXI_LITE.Master                   axi_master_port,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ-1:0][31:0]  addr_i,
    input  logic [NUM_REQ-1:0][31:0]  wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [31:0]               rdata_o,
    output logic                      err_o,
    output logic                      busy_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WB,
        S_RA,
        S_RD
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:2]        addr_q, addr_d;     // bits [1:0] never reach the bus
    logic [31:0]        wdata_q, wdata_d;
    logic               aw_pend_q, aw_pend_d;
    logic               w_pend_q, w_pend_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               grant;

    // round-robin pick: first requester at or after ptr, wrapping around
    always_comb begin
        int j;
        sel_found = 1'b0;
        sel_idx   = '0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr_q) + i) % NUM_REQ;
            if (!sel_found && req_i[j]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(j);
            end
        end
    end

    // reset gates the grant so it drops immediately, not at the next edge
    assign grant = (state_q == S_IDLE) && sel_found && rst_ni;
    assign gnt_o = grant ? (ONE << sel_idx) : '0;

    // next-state and datapath update
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        rvalid_d  = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant) begin
                    idx_d   = sel_idx;
                    addr_d  = addr_i[sel_idx][31:2];
                    wdata_d = wdata_i[sel_idx];
                    ptr_d   = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                    if (we_i[sel_idx]) begin
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        state_d   = S_RA;
                    end
                end
            end
            S_WR: begin
                // address and data channels retire independently
                if (axi_master_port.aw_ready) aw_pend_d = 1'b0;
                if (axi_master_port.w_ready)  w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d)  state_d   = S_WB;
            end
            S_WB: begin
                if (axi_master_port.b_valid) begin
                    rvalid_d = ONE << idx_q;
                    err_d    = axi_master_port.b_resp[1];
                    state_d  = S_IDLE;
                end
            end
            S_RA: begin
                if (axi_master_port.ar_ready) state_d = S_RD;
            end
            S_RD: begin
                if (axi_master_port.r_valid) begin
                    rvalid_d = ONE << idx_q;
                    rdata_d  = addr_q[2] ? axi_master_port.r_data[63:32]
                                         : axi_master_port.r_data[31:0];
                    err_d    = axi_master_port.r_resp[1];
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and latched transaction registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // bus fields come only from latched registers so they hold while valid
    assign axi_master_port.aw_addr  = {addr_q[31:3], 3'b000};
    assign axi_master_port.ar_addr  = {addr_q[31:3], 3'b000};
    assign axi_master_port.aw_prot  = 3'b000;
    assign axi_master_port.ar_prot  = 3'b000;
    assign axi_master_port.w_data   = {wdata_q, wdata_q};
    assign axi_master_port.w_strb   = addr_q[2] ? 8'hF0 : 8'h0F;
    assign axi_master_port.aw_valid = (state_q == S_WR) && aw_pend_q;
    assign axi_master_port.w_valid  = (state_q == S_WR) && w_pend_q;
    assign axi_master_port.b_ready  = (state_q == S_WB);
    assign axi_master_port.ar_valid = (state_q == S_RA);
    assign axi_master_port.r_ready  = (state_q == S_RD);

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign busy_o   = (state_q != S_IDLE);
endmodule

// File: doc/axi_lite_req_arbiter.md
# axi_lite_req_arbiter

Round-robin arbiter and transaction sequencer that shares one 64-bit AXI-Lite master port between `NUM_REQ` simple 32-bit word requesters, such as the accelerator control unit and its test drivers. It accepts one request at a time and runs the full AXI-Lite write (AW/W/B) or read (AR/R) handshake. It then returns a one-cycle completion pulse with read data and error status to the granted requester. Only one transaction is outstanding at any time.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be 2..8.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `axi_master_port`  AXI_LITE.Master  -  32-bit address, 64-bit data, 8-bit strobe.
- `req_i`  in  NUM_REQ  per-requester request; held high until `gnt_o`.
- `we_i`  in  NUM_REQ  1 = write, 0 = read; sampled with `req_i`.
- `addr_i`  in  NUM_REQ×32  byte address; bits [1:0] ignored, bit 2 selects the 32-bit lane.
- `wdata_i`  in  NUM_REQ×32  write word.
- `gnt_o`  out  NUM_REQ  one-hot, one-cycle pulse; the request is accepted and its fields are latched.
- `rvalid_o`  out  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester.
- `rdata_o`  out  32  read word; valid with `rvalid_o`; holds its value otherwise.
- `err_o`  out  1  bit 1 of `b_resp`/`r_resp` of the completed access; valid with `rvalid_o`.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, WR, WB, RA, RD.
- **IDLE**
  - If any `req_i` bit is high, select the first requester at or after `ptr`, with wrap-around.
  - Pulse `gnt_o[k]` combinationally in that cycle.
  - Latch `addr`, `wdata`, `we` and index `k`.
  - Set `ptr` to (k+1) mod NUM_REQ.
  - Go to WR if `we`, else RA.
- **WR**
  - `aw_valid` and `w_valid` are driven from independent pending flags, both set on entry.
  - Each flag clears on its own ready handshake.
  - Go to WB when both are done; this includes both completing in the same cycle, or the second completing in a later cycle.
- **WB**
  - `b_ready`=1.
  - On `b_valid`: register the completion, then go to IDLE.
- **RA**
  - `ar_valid`=1 until `ar_ready`, then go to RD.
- **RD**
  - `r_ready`=1.
  - On `r_valid`: capture `r_data[63:32]` if latched addr[2], else `r_data[31:0]`; register the completion; go to IDLE.
- **AXI fields**
  - `aw_addr`/`ar_addr` = {addr[31:3], 3'b000}.
  - `w_data` = {wdata, wdata}.
  - `w_strb` = addr[2] ? 8'hF0 : 8'h0F.
  - `aw_prot`/`ar_prot` = 0.
  - `b_ready`=1 only in WB; `r_ready`=1 only in RD.
  - All fields are driven from latched registers, so they are stable while valid is high.
- **Arbitration**
  - A request dropped before its grant is ignored.
  - No new request is accepted until the FSM has returned to IDLE.

## Timing
- **Reset values**
  - FSM = IDLE, `ptr`=0, pending flags 0.
  - `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `busy_o`=0.
  - All AXI valid/ready outputs = 0.
- **Write latency** (grant in cycle 0, zero-wait slave)
  - AW/W handshake in cycle 1.
  - B handshake in cycle 2.
  - `rvalid_o` in cycle 3.
  - Next grant earliest in cycle 3 (the IDLE cycle).
- **Read latency** (zero-wait slave)
  - AR handshake in cycle 1.
  - R in cycle 2.
  - `rvalid_o`/`rdata_o` in cycle 3.
- **Wait states:** each ready/valid wait cycle adds exactly one cycle; there is no timeout.
- **Completion outputs:** `rvalid_o`, `rdata_o` and `err_o` are registered, appearing one cycle after the B/R handshake.
- **Completion and new grant:** may coincide in the same cycle for different or identical requesters.
- **Unsolicited responses:** a `b_valid` or `r_valid` outside WB/RD is not accepted, because the corresponding ready is 0.
- **Reset mid-transaction:** all state and outputs return to reset values immediately, without completing the AXI handshake. The system reset is required to reset the slave as well.

## Test plan
- **Single write:** req 0, we=1, addr 0x8000_0004, wdata 0xDEAD_BEEF, zero-wait slave.
  - Required: `aw_addr` 0x8000_0000, `w_data` 0xDEADBEEF_DEADBEEF, `w_strb` 0xF0.
  - Required: `rvalid_o[0]` 3 cycles after `gnt_o[0]`, `err_o`=0.
- **Single read:** req 2, addr 0x8000_0010, slave returns `r_data` 0x1111_2222_3333_4444.
  - Required: `rdata_o`=0x3333_4444 and `rvalid_o[2]` in cycle 3.
  - Repeat with addr 0x8000_0014; required: `rdata_o`=0x1111_2222.
- **Round-robin:** all four `req_i` held high continuously.
  - Required grant order: 0,1,2,3,0.
  - With only req 1 and req 3 high after `ptr`=2: required grants 3 then 1.
- **Split write channels:** `aw_ready` delayed 3 cycles, `w_ready` immediate, then the reverse.
  - Required: each valid deasserts only after its own handshake.
  - Required: `b_ready` rises the cycle after the later handshake.
- **Error response:** `r_resp`=2'b10 on a read.
  - Required: `err_o`=1 with `rvalid_o`; `err_o` is 0 on the next OKAY completion.
- **Reset in WB:** assert `rst_ni`=0 while waiting for `b_valid`.
  - Required: `busy_o`, `aw_valid`, `b_ready` and `gnt_o` go low asynchronously; `ptr` returns to 0.
  - Required: after release, the first grant goes to the lowest pending index.
